// File: rtl/dcache_port_arbiter.sv
// dcache_port_arbiter
//
// Purpose:
//   Shares the single data-cache request port between the load unit's data
//   stage (reads) and the store queue's retire path (writes). One request is
//   held in an output register until the cache accepts it. Loads win by
//   default. A starvation counter and an urgent input give stores a
//   guaranteed path forward. A held load can be squashed on mispredict.
//
// Ports:
//   clock, reset             system clock, asynchronous active-high reset
//   load_req_*               load request (valid/addr) and its ready grant
//   store_req_*              store request (valid/addr/data/mask/urgent)
//                            and its ready grant
//   load_squash              kills a held, unaccepted load; blocks new load grant
//   cache_req_*              registered request toward the dcache controller
//   cache_req_accepted       cache consumed the current request this cycle
//   starve_cnt               debug view of the starvation counter
module dcache_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MASK_W       = 4,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_req_valid,
  input  logic [ADDR_W-1:0] load_req_addr,
  output logic              load_req_ready,
  input  logic              store_req_valid,
  input  logic [ADDR_W-1:0] store_req_addr,
  input  logic [DATA_W-1:0] store_req_data,
  input  logic [MASK_W-1:0] store_req_mask,
  input  logic              store_req_urgent,
  output logic              store_req_ready,
  input  logic              load_squash,
  output logic              cache_req_valid,
  output logic              cache_req_is_store,
  output logic [ADDR_W-1:0] cache_req_addr,
  output logic [DATA_W-1:0] cache_req_data,
  output logic [MASK_W-1:0] cache_req_mask,
  input  logic              cache_req_accepted,
  output logic [CNT_W-1:0]  starve_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] StarveLimitC = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] StarveMaxC   = '1;

  state_t            state_q, state_d;
  logic              isStore_q, isStore_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [MASK_W-1:0] mask_q, mask_d;
  logic [CNT_W-1:0]  starve_q, starve_d;

  logic slotFree;
  logic loadEligible;
  logic starved;
  logic storeWins;
  logic loadWins;

  // Arbitration, next-state and capture logic. The slot is free when nothing
  // is held, when the held request leaves this cycle, or when a held load is
  // squashed. A squash that coincides with acceptance is simply an accept;
  // both free the slot identically, so no special case is needed. Stores win
  // when urgent, when starved, or when no load can be granted.
  always_comb begin
    state_d   = state_q;
    isStore_d = isStore_q;
    addr_d    = addr_q;
    data_d    = data_q;
    mask_d    = mask_q;
    starve_d  = starve_q;

    slotFree = (state_q == IDLE)
            || ((state_q == HOLD) && cache_req_accepted)
            || ((state_q == HOLD) && !isStore_q && load_squash);
    loadEligible = load_req_valid && !load_squash;
    starved      = (starve_q >= StarveLimitC);
    storeWins    = slotFree && store_req_valid
                && (store_req_urgent || starved || !loadEligible);
    loadWins     = slotFree && !storeWins && loadEligible;

    if (storeWins) begin
      state_d   = HOLD;
      isStore_d = 1'b1;
      addr_d    = store_req_addr;
      data_d    = store_req_data;
      mask_d    = store_req_mask;
      starve_d  = '0;
    end else if (loadWins) begin
      state_d   = HOLD;
      isStore_d = 1'b0;
      addr_d    = load_req_addr;
      data_d    = '0;
      mask_d    = '1;
      // Only a store that was actually waiting counts as losing a cycle.
      if (store_req_valid && (starve_q != StarveMaxC)) begin
        starve_d = starve_q + 1'b1;
      end
    end else if (slotFree) begin
      state_d = IDLE;
    end
  end

  // Grants are suppressed while reset is asserted so no requester believes
  // it was captured by a register that is being cleared.
  always_comb begin
    load_req_ready  = loadWins && !reset;
    store_req_ready = storeWins && !reset;
  end

  // State and output register. Reset drops any held request immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      isStore_q <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      mask_q    <= '0;
      starve_q  <= '0;
    end else begin
      state_q   <= state_d;
      isStore_q <= isStore_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      mask_q    <= mask_d;
      starve_q  <= starve_d;
    end
  end

  assign cache_req_valid    = (state_q == HOLD);
  assign cache_req_is_store = isStore_q;
  assign cache_req_addr     = addr_q;
  assign cache_req_data     = data_q;
  assign cache_req_mask     = mask_q;
  assign starve_cnt         = starve_q;

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// tb_dcache_port_arbiter
//
// Purpose:
//   Self-checking bench for dcache_port_arbiter. Directed scenarios followed
//   by randomized traffic; every cycle is compared against a behavioural
//   model that tracks "what is held", "how long stores have waited" and
//   applies the arbitration rules directly.
module tb_dcache_port_arbiter;

  localparam int ADDR_W       = 32;
  localparam int DATA_W       = 32;
  localparam int MASK_W       = 4;
  localparam int STARVE_LIMIT = 4;
  localparam int CNT_W        = 3;
  localparam int STARVE_MAX   = (1 << CNT_W) - 1;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              load_req_valid = 1'b0;
  logic [ADDR_W-1:0] load_req_addr = '0;
  logic              load_req_ready;
  logic              store_req_valid = 1'b0;
  logic [ADDR_W-1:0] store_req_addr = '0;
  logic [DATA_W-1:0] store_req_data = '0;
  logic [MASK_W-1:0] store_req_mask = '0;
  logic              store_req_urgent = 1'b0;
  logic              store_req_ready;
  logic              load_squash = 1'b0;
  logic              cache_req_valid;
  logic              cache_req_is_store;
  logic [ADDR_W-1:0] cache_req_addr;
  logic [DATA_W-1:0] cache_req_data;
  logic [MASK_W-1:0] cache_req_mask;
  logic              cache_req_accepted = 1'b0;
  logic [CNT_W-1:0]  starve_cnt;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: the request currently owned by the cache port and the
  // number of consecutive cycles a waiting store has lost to a load.
  bit          mHeld;
  bit          mIsStore;
  logic [31:0] mAddr;
  logic [31:0] mData;
  logic [3:0]  mMask;
  int          mStarve;

  dcache_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W),
    .STARVE_LIMIT(STARVE_LIMIT), .CNT_W(CNT_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .load_req_valid(load_req_valid),
    .load_req_addr(load_req_addr),
    .load_req_ready(load_req_ready),
    .store_req_valid(store_req_valid),
    .store_req_addr(store_req_addr),
    .store_req_data(store_req_data),
    .store_req_mask(store_req_mask),
    .store_req_urgent(store_req_urgent),
    .store_req_ready(store_req_ready),
    .load_squash(load_squash),
    .cache_req_valid(cache_req_valid),
    .cache_req_is_store(cache_req_is_store),
    .cache_req_addr(cache_req_addr),
    .cache_req_data(cache_req_data),
    .cache_req_mask(cache_req_mask),
    .cache_req_accepted(cache_req_accepted),
    .starve_cnt(starve_cnt)
  );

  always #5 clock = ~clock;

  // One comparison: counts it and reports any difference.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle's worth of inputs just after the falling edge.
  task automatic applyStimulus(input bit lv, input logic [31:0] la,
                               input bit sv, input logic [31:0] sa,
                               input logic [31:0] sd, input logic [3:0] sm,
                               input bit urg, input bit sq, input bit acc);
    @(negedge clock);
    load_req_valid     = lv;
    load_req_addr      = la;
    store_req_valid    = sv;
    store_req_addr     = sa;
    store_req_data     = sd;
    store_req_mask     = sm;
    store_req_urgent   = urg;
    load_squash        = sq;
    cache_req_accepted = acc;
  endtask

  task automatic resetModel();
    mHeld    = 1'b0;
    mIsStore = 1'b0;
    mAddr    = '0;
    mData    = '0;
    mMask    = '0;
    mStarve  = 0;
  endtask

  // Compare DUT against the model for the current inputs, then advance the
  // model across the next rising edge.
  task automatic stepModel(input string tag, output bit loadGo, output bit storeGo);
    bit          slotFree;
    bit          loadOk;
    logic [31:0] nAddr;
    logic [31:0] nData;
    logic [3:0]  nMask;
    #1;
    slotFree = !mHeld || cache_req_accepted || (!mIsStore && load_squash);
    loadOk   = load_req_valid && !load_squash;
    storeGo  = slotFree && store_req_valid
            && (store_req_urgent || (mStarve >= STARVE_LIMIT) || !loadOk);
    loadGo   = slotFree && loadOk && !storeGo;

    checkOutput({tag, ".loadReady"}, 64'(load_req_ready), 64'(loadGo));
    checkOutput({tag, ".storeReady"}, 64'(store_req_ready), 64'(storeGo));
    checkOutput({tag, ".valid"}, 64'(cache_req_valid), 64'(mHeld));
    checkOutput({tag, ".starve"}, 64'(starve_cnt), 64'(mStarve));
    if (mHeld) begin
      checkOutput({tag, ".isStore"}, 64'(cache_req_is_store), 64'(mIsStore));
      checkOutput({tag, ".addr"}, 64'(cache_req_addr), 64'(mAddr));
      checkOutput({tag, ".data"}, 64'(cache_req_data), 64'(mData));
      checkOutput({tag, ".mask"}, 64'(cache_req_mask), 64'(mMask));
    end

    nAddr = storeGo ? store_req_addr : load_req_addr;
    nData = storeGo ? store_req_data : 32'h0;
    nMask = storeGo ? store_req_mask : 4'hF;

    @(posedge clock);
    if (storeGo || loadGo) begin
      mHeld    = 1'b1;
      mIsStore = storeGo;
      mAddr    = nAddr;
      mData    = nData;
      mMask    = nMask;
    end else if (slotFree) begin
      mHeld = 1'b0;
    end
    if (storeGo) mStarve = 0;
    else if (loadGo && store_req_valid && mStarve < STARVE_MAX) mStarve = mStarve + 1;
  endtask

  // Directed scenarios followed by randomized traffic.
  initial begin
    bit          lg, sg;
    bit          lp, sp, urg, sq, acc;
    logic [31:0] la, sa, sd;
    logic [3:0]  sm;
    int          storeCount;

    resetModel();

    // Reset asserted with a load already requesting: no grant, nothing held.
    #1 reset = 1'b1;
    load_req_valid = 1'b1;
    load_req_addr  = 32'h40;
    #1;
    checkOutput("rst.loadReady", 64'(load_req_ready), 64'd0);
    checkOutput("rst.storeReady", 64'(store_req_ready), 64'd0);
    checkOutput("rst.valid", 64'(cache_req_valid), 64'd0);
    checkOutput("rst.starve", 64'(starve_cnt), 64'd0);
    checkOutput("rst.addr", 64'(cache_req_addr), 64'd0);
    repeat (2) @(posedge clock);

    // Reset release: the waiting load is granted in that same cycle.
    applyStimulus(1, 32'h40, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    #1 checkOutput("rel.loadReady", 64'(load_req_ready), 64'd1);
    stepModel("rel", lg, sg);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 checkOutput("rel.heldAddr", 64'(cache_req_addr), 64'h40);
    checkOutput("rel.heldIsStore", 64'(cache_req_is_store), 64'd0);
    stepModel("relHold", lg, sg);

    // Continuous contention with acceptance every cycle: L,L,L,L,S repeating.
    storeCount = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 32'h100 + 32'(i), 1, 32'h200 + 32'(storeCount),
                    32'hA000 + 32'(storeCount), 4'h5, 0, 0, 1);
      #1;
      checkOutput("pattern.starve", 64'(starve_cnt), 64'(i % 5));
      checkOutput("pattern.storeWin", 64'(store_req_ready), 64'((i % 5) == 4));
      stepModel("pattern", lg, sg);
      if (sg) storeCount++;
    end

    // Urgent store beats a valid load even with the counter at zero.
    applyStimulus(1, 32'h300, 1, 32'h310, 32'h5555AAAA, 4'h9, 1, 0, 1);
    #1;
    checkOutput("urgent.storeReady", 64'(store_req_ready), 64'd1);
    checkOutput("urgent.loadReady", 64'(load_req_ready), 64'd0);
    stepModel("urgent", lg, sg);

    // Held load 0x1000, not accepted for three cycles, then squashed.
    applyStimulus(1, 32'h1000, 0, 0, 0, 0, 0, 0, 1);
    stepModel("hold.grant", lg, sg);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 32'h2000, 1, 32'h3000, 32'hCAFEBABE, 4'h3, 0, 0, 0);
      #1;
      checkOutput("hold.addr", 64'(cache_req_addr), 64'h1000);
      checkOutput("hold.anyReady", 64'(load_req_ready | store_req_ready), 64'd0);
      stepModel("hold", lg, sg);
    end
    applyStimulus(1, 32'h2000, 1, 32'h3000, 32'hCAFEBABE, 4'h3, 0, 1, 0);
    #1 checkOutput("squash.storeReady", 64'(store_req_ready), 64'd1);
    stepModel("squash", lg, sg);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("squash.isStore", 64'(cache_req_is_store), 64'd1);
    checkOutput("squash.addr", 64'(cache_req_addr), 64'h3000);
    stepModel("squashNext", lg, sg);

    // Squash coinciding with acceptance: accepted, and the squashed new
    // load is not granted.
    applyStimulus(1, 32'h4000, 0, 0, 0, 0, 0, 0, 1);
    stepModel("sqAcc.grant", lg, sg);
    applyStimulus(1, 32'h5000, 0, 0, 0, 0, 0, 1, 1);
    #1 checkOutput("sqAcc.loadReady", 64'(load_req_ready), 64'd0);
    stepModel("sqAcc", lg, sg);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 checkOutput("sqAcc.validAfter", 64'(cache_req_valid), 64'd0);
    stepModel("sqAccNext", lg, sg);

    // Held store, reset mid-HOLD clears the request immediately.
    applyStimulus(0, 0, 1, 32'h6000, 32'h12345678, 4'hC, 0, 0, 0);
    stepModel("rstHold.grant", lg, sg);
    applyStimulus(1, 32'h7000, 0, 0, 0, 0, 0, 0, 0);
    stepModel("rstHold.hold", lg, sg);
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    checkOutput("rstHold.valid", 64'(cache_req_valid), 64'd0);
    checkOutput("rstHold.starve", 64'(starve_cnt), 64'd0);
    checkOutput("rstHold.loadReady", 64'(load_req_ready), 64'd0);
    resetModel();

    // Randomized traffic; requesters hold their fields until granted.
    lp = 0; sp = 0; la = '0; sa = '0; sd = '0; sm = '0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    stepModel("randStart", lg, sg);
    for (int c = 0; c < 400; c++) begin
      if (!lp && $urandom_range(0, 3) != 0) begin
        lp = 1;
        la = $urandom;
      end
      if (!sp && $urandom_range(0, 2) == 0) begin
        sp = 1;
        sa = $urandom;
        sd = $urandom;
        sm = 4'($urandom_range(0, 15));
      end
      urg = sp && ($urandom_range(0, 9) == 0);
      sq  = ($urandom_range(0, 9) == 0);
      acc = ($urandom_range(0, 9) < 7);
      applyStimulus(lp, la, sp, sa, sd, sm, urg, sq, acc);
      stepModel("rand", lg, sg);
      if (lg) lp = 0;
      if (sg) sp = 0;
      if (sq && lp && ($urandom_range(0, 1) == 1)) lp = 0;
    end

    // Final asynchronous reset from whatever state the traffic left.
    #2 reset = 1'b1;
    #1;
    checkOutput("final.valid", 64'(cache_req_valid), 64'd0);
    checkOutput("final.starve", 64'(starve_cnt), 64'd0);
    checkOutput("final.storeReady", 64'(store_req_ready), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/dcache_port_arbiter.md
Name: dcache_port_arbiter

Overview:
- Shares the single data-cache request port between the load unit's data stage (reads) and the store queue's retire path (writes).
- Holds one registered request toward the cache until the cache accepts it. Loads have priority by default; a starvation counter and an urgent input guarantee store forward progress.
- Supports squashing a held load on branch mispredict.
- Sits between load_data_stage/store queue and the dcache controller.

Parameters:
ADDR_W, 32, request address width
DATA_W, 32, store data width
MASK_W, 4, byte-mask width (DATA_W/8)
STARVE_LIMIT, 4, consecutive store-losing cycles before stores win priority
CNT_W, 3, starvation counter width; must satisfy 2^CNT_W > STARVE_LIMIT

Ports:
clock  in  1  system clock
reset  in  1  asynchronous active-high reset
load_req_valid  in  1  load data stage has a read request
load_req_addr  in  ADDR_W  load address
load_req_ready  out  1  load request captured this cycle (combinational)
store_req_valid  in  1  store queue head ready to write
store_req_addr  in  ADDR_W  store address
store_req_data  in  DATA_W  store data
store_req_mask  in  MASK_W  store byte mask
store_req_urgent  in  1  store queue full; store wins priority
store_req_ready  out  1  store request captured this cycle (combinational)
load_squash  in  1  mispredict kills any held, unaccepted load
cache_req_valid  out  1  registered request valid
cache_req_is_store  out  1  1 = write, 0 = read
cache_req_addr  out  ADDR_W  registered address
cache_req_data  out  DATA_W  registered store data (0 for loads)
cache_req_mask  out  MASK_W  registered mask (all ones for loads)
cache_req_accepted  in  1  cache consumed the current request this cycle
starve_cnt  out  CNT_W  debug view of the starvation counter

Behaviour:
- Reset is asynchronous and active-high. On reset: state=IDLE; cache_req_valid=0; is_store/addr/data/mask=0; starve_cnt=0.
- Ready outputs are 0 while reset is asserted.
- States:
  - IDLE: no request held.
  - HOLD: request held, waiting for acceptance.
- slot_free = (state==IDLE) || (state==HOLD && cache_req_accepted) || (state==HOLD && is_store==0 && load_squash).
- Winner selection, evaluated only when slot_free:
  - store wins if store_req_valid and (store_req_urgent or starve_cnt>=STARVE_LIMIT or !load_eligible);
  - otherwise load wins if load_eligible.
  - load_eligible = load_req_valid && !load_squash.
- Grant outputs:
  - load_req_ready = slot_free && load wins.
  - store_req_ready = slot_free && store wins.
  - At most one ready per cycle. Ready never depends on the requester's own ready.
- Capture: on a grant, the output register loads the winner's fields and the state becomes HOLD, with cache_req_valid=1 on the next edge.
- Back-to-back: acceptance and a new grant in the same cycle give a new request the next cycle. Zero bubble, full throughput of 1 request per cycle.
- HOLD with no acceptance and no squash: all output fields stay stable. Requesters must keep their inputs stable until ready.
- Acceptance with no new grant: go to IDLE, cache_req_valid=0 next cycle.
- Squash:
  - Held load, not accepted, load_squash=1: the load is dropped (state frees).
  - If cache_req_accepted=1 in the same cycle, acceptance wins; downstream discards the response by branch mask.
  - A held store is never squashed.
  - load_squash also blocks a new load grant that cycle; a store may still be granted.
- Starvation counter:
  - Increments (saturating at 2^CNT_W-1) each cycle in which store_req_valid=1 and a load is granted.
  - Clears on any store grant.
  - Holds otherwise, including cycles with no grant.
- Reset mid-HOLD drops the held request immediately. No acceptance is owed.
- Loads get mask all ones and data 0.

Test Plan:
- Reset with load_req_valid=1 asserted → ready=0, cache_req_valid=0. Release reset → load_req_ready=1 that cycle; next cycle cache_req_valid=1, is_store=0, addr matches.
- Load and store both valid every cycle, cache_req_accepted=1 constantly, STARVE_LIMIT=4 → grant pattern L,L,L,L,S repeating; starve_cnt 0,1,2,3,4,0.
- store_req_urgent=1 with load also valid → store granted first; starve_cnt=0.
- Held load 0x1000, cache_req_accepted=0 for 3 cycles → outputs stable and no ready. Then load_squash=1 with a store valid → store granted that cycle; next cycle is_store=1, load never appears.
- Held load with load_squash=1 and cache_req_accepted=1 in the same cycle → treated as accepted; a new load with load_squash high is not granted that cycle.
- Held store, assert reset mid-HOLD → cache_req_valid=0 immediately (async) and starve_cnt=0.
